alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have port alu_control  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLL, 110 SRL, 111 reserved.
REQ-007 SHALL have port src_a  input  WIDTH  operand A.
REQ-008 SHALL have port src_b  input  WIDTH  operand B; shift amount = src_b[log2(WIDTH)-1:0].
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  high when result == 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; accept = in_valid && in_ready.
REQ-015 SHALL sample alu_control, src_a, src_b only on the accept edge; input changes at other times are ignored.
REQ-016 SHALL, for codes 000-100 and 111, write result on the accept edge and enter DONE (out_valid 1 cycle after accept).
REQ-017 SHALL compute ADD/SUB modulo 2^WIDTH, discarding carry/borrow.
REQ-018 SHALL compute SLT as signed two's-complement src_a < src_b, result 1 or 0 zero-extended.
REQ-019 SHALL treat code 111 as ADD.
REQ-020 SHALL, for SLL/SRL with shift amount 0, load result = src_a and enter DONE on the accept edge.
REQ-021 SHALL, for SLL/SRL with shift amount N>0, load src_a and counter N, enter SHIFT, shift one bit (logical, zero fill) per cycle, and enter DONE on the edge where counter reaches 0; out_valid rises exactly N cycles after the accept edge.
REQ-022 SHALL hold out_valid, result and zero stable in DONE until out_valid && out_ready.
REQ-023 SHALL return to IDLE on the handoff edge; in_ready is low during the handoff cycle (no same-cycle re-accept).
REQ-024 SHALL keep result and zero unchanged in IDLE after handoff until the next write.
REQ-025 SHALL derive zero combinationally from the result register.

Reset
REQ-026 SHALL on reset force state IDLE, out_valid 0, result 0 (zero 1), shift counter 0, in_ready 1 after deassertion.
REQ-027 SHALL abandon any in-flight SHIFT or unconsumed DONE result on reset, without emitting out_valid.

Configuration
REQ-028 SHALL, with ALU_SHIFT_EN defined, implement SLL/SRL per REQ-020/021.
REQ-029 SHALL, without ALU_SHIFT_EN, omit SHIFT state and counter, treat codes 101/110 as ADD with 1-cycle latency.

Verification
REQ-030 SHALL cover: ADD 0xFFFFFFFF + 0x1, out_ready=1 -> out_valid 1 cycle after accept, result 0x0, zero 1.
REQ-031 SHALL cover: SLT src_a 0xFFFFFFFF, src_b 0x1 -> result 0x1; SUB 5 - 7 -> 0xFFFFFFFE, zero 0.
REQ-032 SHALL cover (ALU_SHIFT_EN): SLL 0x1 by 31 -> out_valid exactly 31 cycles after accept, result 0x80000000; SRL by 0 -> 1 cycle, result = src_a.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready 0, in_valid pulses ignored; handoff -> IDLE next cycle.
REQ-034 SHALL cover: reset asserted mid-SHIFT (SRL by 20, cycle 8) -> immediately IDLE, out_valid 0, result 0, no late out_valid.
REQ-035 SHALL cover (no ALU_SHIFT_EN): code 101 with 3, 4 -> result 7 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: ADD/SUB/AND/OR/SLT in one cycle, optional bit-serial SLL/SRL.
// Define ALU_SHIFT_EN to build the multi-cycle shifter; otherwise codes 101/110 act as ADD.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_lt;
    logic             w_accept;

`ifdef ALU_SHIFT_EN
    logic [SHW-1:0]   r_count;
    logic             r_dir_right;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic             w_shift_start;

    assign w_shamt       = src_b[SHW-1:0];
    assign w_is_shift    = (alu_control == 3'b101) || (alu_control == 3'b110);
    assign w_shift_start = w_is_shift && (w_shamt != '0);
`endif

    assign w_accept  = in_valid && in_ready;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = (r_result == '0);

    assign w_lt = $signed(src_a) < $signed(src_b);

    // Non-shift codes (and 111) resolve in a single cycle; shift codes fall back to ADD here.
    always_comb begin
        w_alu_res = src_a + src_b;
        case (alu_control)
            3'b001:  w_alu_res = src_a - src_b;
            3'b010:  w_alu_res = src_a & src_b;
            3'b011:  w_alu_res = src_a | src_b;
            3'b100:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            default: w_alu_res = src_a + src_b;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef ALU_SHIFT_EN
                    w_state_next = w_shift_start ? SHIFT : DONE;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef ALU_SHIFT_EN
            SHIFT: begin
                if (r_count == SHW'(1)) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_result <= '0;
`ifdef ALU_SHIFT_EN
            r_count     <= '0;
            r_dir_right <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
`ifdef ALU_SHIFT_EN
                if (w_is_shift) begin
                    // Shift amount 0 just passes src_a through with single-cycle latency.
                    r_result    <= src_a;
                    r_count     <= w_shamt;
                    r_dir_right <= alu_control[1];
                end else begin
                    r_result <= w_alu_res;
                end
`else
                r_result <= w_alu_res;
`endif
            end
`ifdef ALU_SHIFT_EN
            else if (r_state == SHIFT) begin
                r_result <= r_dir_right ? (r_result >> 1) : (r_result << 1);
                r_count  <= r_count - SHW'(1);
            end
`endif
        end
    end

endmodule
